flex_updown_counter: RTL and testbench

Parametrised successor to the team's flex counter. Counts over the run range 1..rollover_val in either direction. Adds a per-cycle direction select, wrap or saturate mode, synchronous parallel load and an enable prescaler. Used by timing and bit-period logic that needs divided tick rates, reload values or countdowns.

---
 rtl/flex_updown_counter.sv | 103 ++++++++++
 tb/tb_flex_updown_counter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/flex_updown_counter.sv
// flex_updown_counter: up/down counter over the run range 1..rollover_val.
// Supports wrap or saturate at the limits, synchronous parallel load and an
// enable prescaler. The flag and the wrap pulse are registered from the
// next-state value, so both line up with the count_out value they describe.
module flex_updown_counter #(
  parameter int NUM_CNT_BITS = 8,
  parameter int NUM_PRE_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    count_up,
  input  logic                    saturate,
  input  logic [NUM_PRE_BITS-1:0] prescale_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);
  localparam logic [NUM_PRE_BITS-1:0] PRE_ONE = NUM_PRE_BITS'(1);

  logic [NUM_PRE_BITS-1:0] pre;
  logic [NUM_PRE_BITS-1:0] pre_next;
  logic [NUM_CNT_BITS-1:0] step_val;
  logic                    step_wrap;
  logic [NUM_CNT_BITS-1:0] cnt_next;
  logic                    wrap_next;

  // Value the count would take if a step happened this cycle.
  // Counts above R snap back to R (down) or wrap/saturate (up).
  always_comb begin
    step_val  = count_out;
    step_wrap = 1'b0;
    if (rollover_val == '0) begin
      step_val = '0;
    end else if (count_up) begin
      if (count_out < rollover_val) begin
        step_val = count_out + CNT_ONE;
      end else if (saturate) begin
        step_val = rollover_val;
      end else begin
        step_val  = CNT_ONE;
        step_wrap = 1'b1;
      end
    end else begin
      if ((count_out == '0) || (count_out > rollover_val)) begin
        step_val = rollover_val;
      end else if (count_out != CNT_ONE) begin
        step_val = count_out - CNT_ONE;
      end else if (saturate) begin
        step_val = CNT_ONE;
      end else begin
        step_val  = rollover_val;
        step_wrap = 1'b1;
      end
    end
  end

  // Next-state selection: clear > load > prescaled step > hold.
  // The prescaler free-runs past prescale_val and wraps, so lowering
  // prescale_val mid-count just delays the next step.
  always_comb begin
    cnt_next  = count_out;
    pre_next  = pre;
    wrap_next = 1'b0;
    if (clear) begin
      cnt_next = '0;
      pre_next = '0;
    end else if (load) begin
      cnt_next = load_val;
      pre_next = '0;
    end else if (count_enable) begin
      if (pre == prescale_val) begin
        pre_next  = '0;
        cnt_next  = step_val;
        wrap_next = step_wrap;
      end else begin
        pre_next = pre + PRE_ONE;
      end
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_out     <= '0;
      pre           <= '0;
      rollover_flag <= 1'b0;
      wrap_pulse    <= 1'b0;
    end else begin
      count_out     <= cnt_next;
      pre           <= pre_next;
      rollover_flag <= (cnt_next == rollover_val);
      wrap_pulse    <= wrap_next;
    end
  end

endmodule

// File: tb/tb_flex_updown_counter.sv
// Testbench for flex_updown_counter: directed sequences with literal
// expectations, then randomized stimulus checked every cycle against a
// behavioural model.
module tb_flex_updown_counter;

  localparam int CW = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst, clear, load, count_enable, count_up, saturate;
  logic [CW-1:0] load_val, rollover_val;
  logic [PW-1:0] prescale_val;
  logic [CW-1:0] count_out;
  logic          rollover_flag, wrap_pulse;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // behavioural model state
  int m_cnt = 0, m_pre = 0, m_nxt;
  bit m_flag = 0, m_wrap = 0, m_w;

  flex_updown_counter #(.NUM_CNT_BITS(CW), .NUM_PRE_BITS(PW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_up(count_up), .saturate(saturate),
    .prescale_val(prescale_val), .rollover_val(rollover_val),
    .count_out(count_out), .rollover_flag(rollover_flag), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  // Where one step lands, stated in terms of the run range 1..R.
  function automatic int model_step(input int c, input int r, input bit up,
                                    input bit sat, output bit w);
    w = 0;
    if (r == 0) return 0;
    if (up) begin
      if (c < r) return c + 1;
      if (sat) return r;
      w = 1;
      return 1;
    end
    if (c == 0 || c > r) return r;
    if (c > 1) return c - 1;
    if (sat) return 1;
    w = 1;
    return r;
  endfunction

  // model update on each rising edge
  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_flag = 0; m_wrap = 0;
    end else begin
      m_nxt = m_cnt;
      m_w   = 0;
      if (clear) begin
        m_nxt = 0; m_pre = 0;
      end else if (load) begin
        m_nxt = int'(load_val); m_pre = 0;
      end else if (count_enable) begin
        if (m_pre == int'(prescale_val)) begin
          m_pre = 0;
          m_nxt = model_step(m_cnt, int'(rollover_val), count_up, saturate, m_w);
        end else begin
          m_pre = (m_pre + 1) % (1 << PW);
        end
      end
      m_cnt  = m_nxt;
      m_flag = (m_nxt == int'(rollover_val));
      m_wrap = m_w;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (count_out !== CW'(m_cnt) || rollover_flag !== m_flag || wrap_pulse !== m_wrap) begin
        errors++;
        $display("FAIL model t=%0t: got cnt=%0d flag=%b wrap=%b, want cnt=%0d flag=%b wrap=%b",
                 $time, count_out, rollover_flag, wrap_pulse, m_cnt, m_flag, m_wrap);
      end
    end
  end

  task automatic expect_cyc(input int c, input bit f, input bit w, input string nm);
    @(posedge clk); #1;
    checks++;
    if (count_out !== CW'(c) || rollover_flag !== f || wrap_pulse !== w) begin
      errors++;
      $display("FAIL %s: got cnt=%0d flag=%b wrap=%b, want cnt=%0d flag=%b wrap=%b",
               nm, count_out, rollover_flag, wrap_pulse, c, f, w);
    end
  endtask

  initial begin
    rst = 1; clear = 0; load = 0; load_val = '0; count_enable = 1;
    count_up = 1; saturate = 0; prescale_val = '0; rollover_val = 8'd5;

    // reset with enable held
    expect_cyc(0, 0, 0, "reset0");
    started = 1;
    expect_cyc(0, 0, 0, "reset1");
    rst = 0;

    // up run, R=5, wrap
    expect_cyc(1, 0, 0, "up1");
    expect_cyc(2, 0, 0, "up2");
    expect_cyc(3, 0, 0, "up3");
    expect_cyc(4, 0, 0, "up4");
    expect_cyc(5, 1, 0, "up5");
    expect_cyc(1, 0, 1, "upwrap");

    // prescale 2, R=3, with an enable gap
    clear = 1; rollover_val = 8'd3; prescale_val = 4'd2;
    expect_cyc(0, 0, 0, "pclr");
    clear = 0;
    expect_cyc(0, 0, 0, "pre_a");
    expect_cyc(0, 0, 0, "pre_b");
    expect_cyc(1, 0, 0, "pre_c");
    expect_cyc(1, 0, 0, "pre_d");
    count_enable = 0;
    for (int i = 0; i < 4; i++) expect_cyc(1, 0, 0, "pre_hold");
    count_enable = 1;
    expect_cyc(1, 0, 0, "pre_e");
    expect_cyc(2, 0, 0, "pre_f");
    expect_cyc(2, 0, 0, "pre_g");
    expect_cyc(2, 0, 0, "pre_h");
    expect_cyc(3, 1, 0, "pre_i");
    expect_cyc(3, 1, 0, "pre_j");
    expect_cyc(3, 1, 0, "pre_k");
    expect_cyc(1, 0, 1, "pre_wrap");

    // down run R=4, wrap then saturate
    prescale_val = '0; rollover_val = 8'd4; count_up = 0; clear = 1;
    expect_cyc(0, 0, 0, "dclr");
    clear = 0;
    expect_cyc(4, 1, 0, "dn4");
    expect_cyc(3, 0, 0, "dn3");
    expect_cyc(2, 0, 0, "dn2");
    expect_cyc(1, 0, 0, "dn1");
    expect_cyc(4, 1, 1, "dnwrap");
    saturate = 1; clear = 1;
    expect_cyc(0, 0, 0, "sclr");
    clear = 0;
    expect_cyc(4, 1, 0, "sdn4");
    expect_cyc(3, 0, 0, "sdn3");
    expect_cyc(2, 0, 0, "sdn2");
    expect_cyc(1, 0, 0, "sdn1");
    expect_cyc(1, 0, 0, "sat1a");
    expect_cyc(1, 0, 0, "sat1b");

    // load above R
    saturate = 0; rollover_val = 8'd6; load = 1; load_val = 8'd9; count_up = 1;
    expect_cyc(9, 0, 0, "load9");
    load = 0;
    expect_cyc(1, 0, 1, "load_upwrap");
    load = 1;
    expect_cyc(9, 0, 0, "load9b");
    load = 0; count_up = 0;
    expect_cyc(6, 1, 0, "load_dn");

    // clear+load+enable together, then prescaler restart
    prescale_val = 4'd3; count_up = 1;
    expect_cyc(6, 1, 0, "ps3_a");
    expect_cyc(6, 1, 0, "ps3_b");
    clear = 1; load = 1; load_val = 8'd5;
    expect_cyc(0, 0, 0, "clr_ld");
    clear = 0; load = 0;
    expect_cyc(0, 0, 0, "pz1");
    expect_cyc(0, 0, 0, "pz2");
    expect_cyc(0, 0, 0, "pz3");
    expect_cyc(1, 0, 0, "pz4");
    prescale_val = '0; load = 1; load_val = 8'd2;
    expect_cyc(2, 0, 0, "load_no_step");
    load = 0;

    // degenerate R=0
    rollover_val = '0;
    for (int i = 0; i < 3; i++) expect_cyc(0, 1, 0, "r0_up");
    count_up = 0;
    for (int i = 0; i < 3; i++) expect_cyc(0, 1, 0, "r0_dn");
    saturate = 1;
    expect_cyc(0, 1, 0, "r0_sat");

    // reset mid-count
    saturate = 0; count_up = 1; rollover_val = 8'd3;
    expect_cyc(1, 0, 0, "mid1");
    expect_cyc(2, 0, 0, "mid2");
    expect_cyc(3, 1, 0, "mid3");
    rst = 1;
    expect_cyc(0, 0, 0, "mid_rst");
    rst = 0;

    // randomized run, checked by the model process
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      clear        = ($urandom_range(0, 49) == 0);
      load         = ($urandom_range(0, 29) == 0);
      load_val     = CW'($urandom_range(0, 15));
      count_enable = ($urandom_range(0, 3) != 0);
      count_up     = $urandom_range(0, 1);
      saturate     = $urandom_range(0, 1);
      if ($urandom_range(0, 39) == 0)
        prescale_val = ($urandom_range(0, 4) == 0) ? PW'($urandom_range(12, 15))
                                                   : PW'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) rollover_val = CW'($urandom_range(0, 12));
      @(posedge clk); #1;
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
